// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encoding, Nk/Nr lookup,
// Rcon constants, xtime and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    return nk_of(kl) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // SBOX[0] is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: byte-wise S-box substitution of a 32-bit word, purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {SBOX[word[31:24]], SBOX[word[23:16]],
                SBOX[word[15:8]],  SBOX[word[7:0]]};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion into a word store, read back as round keys.
// Optional round-key stream outputs are enabled by defining AES_KEY_SCHED_STREAM_EN.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              key_len,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    keys_valid,
  output logic [3:0]              num_rounds,
  input  logic [3:0]              rd_round,
  output logic [127:0]            rd_key
`ifdef AES_KEY_SCHED_STREAM_EN
  ,
  output logic                    rk_stream_valid,
  output logic [3:0]              rk_stream_idx,
  output logic [127:0]            rk_stream_data
`endif
);

  localparam int MAX_NK   = MAX_KEY_BITS / 32;
  localparam int NTOT_MAX = 4 * (MAX_NK + 7);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_e;

  state_e                  state, state_nxt;
  logic                    accept, reject, legal;
  logic [MAX_KEY_BITS-1:0] key_q;
  logic [3:0]              nk_q, nr_q;
  logic [5:0]              idx_q;
  logic [2:0]              mod_q;
  logic [7:0]              rcon_q;
  logic [31:0]             store [NTOT_MAX];

  logic [31:0] w_prev, w_back, rot, sub_in, sub_out, temp, w_new;
  logic [5:0]  last_idx, rd_base;

  assign busy     = (state != S_IDLE);
  assign last_idx = {nr_q, 2'b00} + 6'd3;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    case (key_e_cast(key_len))
      KL_128:  legal = 1'b1;
      KL_192:  legal = (MAX_KEY_BITS >= 192);
      KL_256:  legal = (MAX_KEY_BITS >= 256);
      default: legal = 1'b0;
    endcase
    case (state)
      S_IDLE:
        if (start) begin
          if (legal) begin
            accept    = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      S_LOAD:   state_nxt = S_EXPAND;
      S_EXPAND: if (idx_q == last_idx) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  function automatic key_len_e key_e_cast(input logic [1:0] v);
    return key_len_e'(v);
  endfunction

  // Word recurrence: w[i] = w[i-Nk] ^ temp, temp chosen by position within the Nk group.
  assign w_prev = store[idx_q - 6'd1];
  assign w_back = store[idx_q - {2'b00, nk_q}];
  assign rot    = {w_prev[23:0], w_prev[31:24]};
  assign sub_in = (mod_q == 3'd0) ? rot : w_prev;

  aes_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (mod_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && mod_q == 3'd4)
      temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      nk_q       <= '0;
      nr_q       <= '0;
      idx_q      <= '0;
      mod_q      <= '0;
      rcon_q     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      keys_valid <= 1'b0;
      num_rounds <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);
      err   <= reject;
      if (accept) begin
        nk_q       <= nk_of(key_e_cast(key_len));
        nr_q       <= nr_of(key_e_cast(key_len));
        idx_q      <= '0;
        keys_valid <= 1'b0;
      end
      case (state)
        S_LOAD: begin
          idx_q  <= {2'b00, nk_q};
          mod_q  <= '0;
          rcon_q <= RCON_INIT;
        end
        S_EXPAND: begin
          idx_q <= idx_q + 6'd1;
          mod_q <= (mod_q == nk_q[2:0] - 3'd1) ? 3'd0 : mod_q + 3'd1;
          if (mod_q == 3'd0) rcon_q <= xtime(rcon_q);
        end
        S_DONE: begin
          keys_valid <= 1'b1;
          num_rounds <= nr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) key_q <= key_in;
  end

  // Store: whole key lands in LOAD, then one expanded word per EXPAND cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NTOT_MAX; j++) store[j] <= '0;
    end else if (state == S_LOAD) begin
      for (int j = 0; j < MAX_NK; j++)
        if (j < int'(nk_q)) store[j] <= key_q[MAX_KEY_BITS-1-32*j -: 32];
    end else if (state == S_EXPAND) begin
      store[idx_q] <= w_new;
    end
  end

  assign rd_base = {rd_round, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_key <= '0;
    else if (keys_valid && rd_round <= num_rounds)
      rd_key <= {store[rd_base], store[rd_base + 6'd1],
                 store[rd_base + 6'd2], store[rd_base + 6'd3]};
    else
      rd_key <= '0;
  end

`ifdef AES_KEY_SCHED_STREAM_EN
  // Rounds whose four words are all written but not yet streamed; idx_q counts words written.
  logic [3:0] sr_q;
  logic       pending;
  logic [5:0] sr_base;

  assign pending = (sr_q < idx_q[5:2]);
  assign sr_base = {sr_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q            <= '0;
      rk_stream_valid <= 1'b0;
      rk_stream_idx   <= '0;
      rk_stream_data  <= '0;
    end else begin
      rk_stream_valid <= pending;
      rk_stream_idx   <= sr_q;
      rk_stream_data  <= {store[sr_base], store[sr_base + 6'd1],
                          store[sr_base + 6'd2], store[sr_base + 6'd3]};
      if (accept)
        sr_q <= '0;
      else if (pending)
        sr_q <= sr_q + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, done, err, keys_valid;
  logic [3:0]   num_rounds, rd_round;
  logic [127:0] rd_key;

  logic         start128;
  logic [1:0]   key_len128;
  logic [127:0] key_in128;
  logic         busy128, done128, err128, keys_valid128;
  logic [3:0]   num_rounds128, rd_round128;
  logic [127:0] rd_key128;

`ifdef AES_KEY_SCHED_STREAM_EN
  logic         sv, sv128;
  logic [3:0]   sidx, sidx128;
  logic [127:0] sdata, sdata128;
  int           s_total = 0;
  int           s_bad = 0;
  logic [3:0]   s_prev = '0;
`endif

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .keys_valid(keys_valid),
    .num_rounds(num_rounds), .rd_round(rd_round), .rd_key(rd_key)
`ifdef AES_KEY_SCHED_STREAM_EN
    , .rk_stream_valid(sv), .rk_stream_idx(sidx), .rk_stream_data(sdata)
`endif
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .key_len(key_len128), .key_in(key_in128),
    .busy(busy128), .done(done128), .err(err128), .keys_valid(keys_valid128),
    .num_rounds(num_rounds128), .rd_round(rd_round128), .rd_key(rd_key128)
`ifdef AES_KEY_SCHED_STREAM_EN
    , .rk_stream_valid(sv128), .rk_stream_idx(sidx128), .rk_stream_data(sdata128)
`endif
  );

`ifdef AES_KEY_SCHED_STREAM_EN
  always @(negedge clk) begin
    if (sv) begin
      if (sidx != 4'd0 && sidx != 4'(s_prev + 4'd1)) s_bad++;
      s_prev = sidx;
      s_total++;
    end
  end
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [3:0] r, input logic [127:0] exp, input string tag);
    logic [127:0] got;
    exp_q.push_back(exp);
    rd_round = r;
    tick();
    got = rd_key;
    chk(tag, got, exp_q.pop_front());
  endtask

  task automatic run_key(input logic [1:0] kl, input logic [255:0] k, input int exp_lat,
                         input logic [3:0] exp_nr, input string tag, input bit poke);
    int lat;
`ifdef AES_KEY_SCHED_STREAM_EN
    int snap;
    snap = s_total;
`endif
    lat      = 0;
    rd_round = 4'd0;
    key_len  = kl;
    key_in   = k;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'd1);
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (n == 20) begin
        chk({tag, "_rd_during_expand"}, rd_key, 128'd0);
        if (poke) begin
          start  = 1'b1;
          key_in = ~k;
        end
      end
      if (n == 21) begin
        start = 1'b0;
        if (poke) chk({tag, "_poke_no_err"}, 128'(err), 128'd0);
      end
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_keys_valid"}, 128'(keys_valid), 128'd1);
    chk({tag, "_num_rounds"}, 128'(num_rounds), 128'(exp_nr));
`ifdef AES_KEY_SCHED_STREAM_EN
    tick();
    chk({tag, "_stream_count"}, 128'(s_total - snap), 128'(exp_nr + 4'd1));
    chk({tag, "_stream_order"}, 128'(s_bad), 128'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_len = 2'b00; key_in = '0; rd_round = '0;
    start128 = 1'b0; key_len128 = 2'b00; key_in128 = '0; rd_round128 = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_num_rounds", 128'(num_rounds), 128'd0);
    chk("rst_rd_key", rd_key, 128'd0);
    chk("rst_rd_key128", rd_key128, 128'd0);

    run_key(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 42, 4'd10, "aes128", 1'b0);
    read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128_r10");
    read_chk(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, "aes128_r0");
    read_chk(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "aes128_r1");
    read_chk(4'd11, 128'h0, "aes128_r11_oob");

    key_len = 2'b11;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("illegal_err", 128'(err), 128'd1);
    chk("illegal_busy", 128'(busy), 128'd0);
    tick();
    chk("illegal_err_pulse", 128'(err), 128'd0);
    chk("illegal_keys_valid", 128'(keys_valid), 128'd1);
    read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "illegal_r10_kept");

    run_key(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
            48, 4'd12, "aes192", 1'b0);
    read_chk(4'd12, 128'he98ba06f448c773c8ecc720401002202, "aes192_r12");
    read_chk(4'd1,  128'h62f8ead2522c6b7bfe0c91f72402f5a5, "aes192_r1");

    run_key(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
            54, 4'd14, "aes256", 1'b1);
    read_chk(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256_r14");
    read_chk(4'd1,  128'h1f352c073b6108d72d9810a30914dff4, "aes256_r1");
    read_chk(4'd15, 128'h0, "aes256_r15_oob");

    key_len128 = 2'b10;
    start128   = 1'b1;
    tick();
    start128 = 1'b0;
    chk("max128_err", 128'(err128), 128'd1);
    chk("max128_busy", 128'(busy128), 128'd0);
    chk("max128_done", 128'(done128), 128'd0);
    chk("max128_state", {num_rounds128, keys_valid128}, 128'd0);
    key_len128 = 2'b00;
    key_in128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start128   = 1'b1;
    tick();
    start128 = 1'b0;
    chk("max128_legal_busy", 128'(busy128), 128'd1);
    chk("max128_legal_err", 128'(err128), 128'd0);

    key_len  = 2'b10;
    rd_round = 4'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_keys_valid", 128'(keys_valid), 128'd0);
    chk("abort_rd_key", rd_key, 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    read_chk(4'd0, 128'h0, "abort_r0_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES key expansion for AES-128, AES-192 and AES-256. Key length is selected at runtime, up to a parametrised maximum.
- Produces one 32-bit schedule word per cycle into an internal round-key store.
- The cipher datapath then reads any round key as 128 bits by round index.
- Replaces per-length combinational expanders with one shared sequential engine.

Parameters:
- MAX_KEY_BITS, 256, largest supported key (128/192/256). Sets key_in width and store depth: 44/52/60 words.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request expansion; sampled only in IDLE
- key_len  in  2  00=128, 01=192, 10=256, 11=illegal
- key_in  in  MAX_KEY_BITS  cipher key, left-aligned; w[0] = key_in[MAX_KEY_BITS-1 -: 32]
- busy  out  1  high from LOAD through DONE
- done  out  1  one-cycle pulse when the schedule is complete
- err  out  1  one-cycle pulse when start is rejected
- keys_valid  out  1  level: store holds a complete schedule
- num_rounds  out  4  Nr of the stored schedule (10/12/14)
- rd_round  in  4  round index to read
- rd_key  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, registered, 1-cycle latency

Behaviour:
- Reset: FSM=IDLE; all outputs 0; word store cleared to 0.
- Nk = 4/6/8; Nr = Nk+6; Ntot = 4*(Nr+1).
- States and transitions:
  - IDLE: start=1 with a legal key_len ≤ MAX_KEY_BITS → capture key and Nk, clear keys_valid, go to LOAD. Otherwise start raises err for 1 cycle and the FSM stays in IDLE.
  - LOAD: write w[0..Nk-1] in one cycle; set i=Nk; go to EXPAND.
  - EXPAND: one word per cycle: w[i] = w[i-Nk] ^ temp.
    - temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod Nk == 0.
    - temp = SubWord(w[i-1]) when Nk==8 and i mod Nk == 4.
    - temp = w[i-1] otherwise.
    - i increments each cycle; after writing w[Ntot-1], go to DONE.
  - DONE: done=1, keys_valid=1, num_rounds=Nr latched; go to IDLE.
- Rcon:
  - Register starts at 8'h01 in LOAD.
  - Advances by xtime (shift left 1, XOR 8'h1B if bit7 was set) after each use.
- Latency from start sampled at edge 0 to the done pulse: 42 (128), 48 (192), 54 (256) cycles.
- start during busy is ignored: no err, no restart.
- rd_key:
  - Registered each cycle from rd_round.
  - rd_round > num_rounds, or keys_valid=0, yields 128'h0.
  - Reads during EXPAND return 0, never partial words.
- Async reset mid-expansion aborts to IDLE and clears the store and keys_valid.
- The mod-Nk counter is a separate 3-bit counter wrapping at Nk-1. No divider is used.

Optional Feature:
- AES_KEY_SCHED_STREAM_EN defined:
  - Adds outputs rk_stream_valid (1), rk_stream_idx (4), rk_stream_data (128).
  - rk_stream_valid pulses for one cycle the cycle after each 4-word group completes, carrying round index and key. Covers rounds 0..Nr in ascending order.
  - Round groups completed in LOAD are emitted in successive cycles in ascending order.
  - The stream never back-pressures the FSM.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package aes_pkg:
  - Key-length enum (KL_128/KL_192/KL_256).
  - NK/NR lookup functions.
  - RCON_INIT=8'h01, XTIME_POLY=8'h1B.
  - AES S-box table constant.
- Sub-module aes_sub_word: four S-box lookups on a 32-bit word, combinational, one instance.

Test Plan:
- AES-128 (FIPS-197 A.1): key 2b7e151628aed2a6abf7158809cf4f3c, key_len=00 → done at cycle 42; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 0 = key.
- AES-192 (A.2): key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done at 48; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 (A.3): key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done at 54; round 14 = fe4890d1e6188d0b046df344706c631e.
- key_len=11 with start → err pulse; busy stays 0; keys_valid unchanged. With MAX_KEY_BITS=128, key_len=10 → err.
- start pulsed during EXPAND → ignored, same final keys. rst_n low mid-EXPAND → IDLE, keys_valid=0, rd_key=0.
- Read rd_round=11 after AES-128 → rd_key=0 one cycle later. Under AES_KEY_SCHED_STREAM_EN: exactly Nr+1 stream pulses, indices 0..Nr.
